// File: rtl/sysbus_arbiter_if.sv
// Purpose: one request/response bus channel (cache side or system-bus side).
// Latency: none, signal bundle only.
// Backpressure: reqcyc is held until reqack; each response beat is held until respack.
// Ports: reqcyc/req/reqtag/respack are driven by the requester (master);
//        reqack/respcyc/resp/resptag are driven by the responder (slave).
interface sysbus_arbiter_if #(
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BUS_DATA_WIDTH = 64
);
    logic                      reqcyc;
    logic [BUS_DATA_WIDTH-1:0] req;
    logic [BUS_TAG_WIDTH-1:0]  reqtag;
    logic                      reqack;
    logic                      respcyc;
    logic [BUS_DATA_WIDTH-1:0] resp;
    logic [BUS_TAG_WIDTH-1:0]  resptag;
    logic                      respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_arbiter.sv
// Purpose: round-robin arbiter sharing one system-bus master port between icache and dcache.
// Latency: grant registers 1 cycle after reqcyc is sampled; reqack/response paths are combinational.
// Backpressure: grant held for request+ack+BEATS-beat burst; the other client waits with reqcyc high.
// Ports: clk, reset (sync, active-high); icache/dcache = client channels (slave side);
//        bus = system-bus channel (master side); owner = current/last grant (0 icache, 1 dcache);
//        busy = transaction in progress.
module sysbus_arbiter #(
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BEATS          = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sysbus_arbiter_if.slave       icache,
    sysbus_arbiter_if.slave       dcache,
    sysbus_arbiter_if.master      bus,
    output logic                  owner,
    output logic                  busy
);
    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_W-1:0]          beat_cnt;
    logic                      reqcyc_q;
    logic [BUS_DATA_WIDTH-1:0] req_q;
    logic [BUS_TAG_WIDTH-1:0]  reqtag_q;

    logic grant_vld;
    logic grant_sel;
    logic in_req;
    logic in_resp;
    logic respack_sel;
    logic beat_done;

    assign in_req  = (state == REQ);
    assign in_resp = (state == RESP);

    // Only the owner's respack is forwarded, and only while a burst is expected;
    // stray bus responses in IDLE/REQ are never acked.
    assign respack_sel = in_resp & (owner ? dcache.respack : icache.respack);
    assign beat_done   = bus.respcyc & respack_sel;

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_sel = owner;
        case (state)
            IDLE: begin
                if (icache.reqcyc && dcache.reqcyc) begin
                    // Tie: the client that did not win last time goes next.
                    grant_vld = 1'b1;
                    grant_sel = ~owner;
                end else if (icache.reqcyc) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b0;
                end else if (dcache.reqcyc) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b1;
                end
                if (grant_vld) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // A response beat coinciding with the ack is ignored here;
                // the bus re-presents it once we are in RESP.
                if (bus.reqack) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (beat_done && beat_cnt == CNT_W'(BEATS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b1;
            beat_cnt <= '0;
            reqcyc_q <= 1'b0;
            req_q    <= '0;
            reqtag_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant_vld) begin
                owner    <= grant_sel;
                reqcyc_q <= 1'b1;
                req_q    <= grant_sel ? dcache.req    : icache.req;
                reqtag_q <= grant_sel ? dcache.reqtag : icache.reqtag;
            end
            if (in_req && bus.reqack) begin
                reqcyc_q <= 1'b0;
                beat_cnt <= '0;
            end
            if (in_resp && beat_done) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assign bus.reqcyc  = reqcyc_q;
    assign bus.req     = req_q;
    assign bus.reqtag  = reqtag_q;
    assign bus.respack = respack_sel;

    assign icache.reqack  = in_req & ~owner & bus.reqack;
    assign dcache.reqack  = in_req &  owner & bus.reqack;

    assign icache.respcyc = in_resp & ~owner & bus.respcyc;
    assign dcache.respcyc = in_resp &  owner & bus.respcyc;
    assign icache.resp    = (in_resp & ~owner) ? bus.resp    : '0;
    assign dcache.resp    = (in_resp &  owner) ? bus.resp    : '0;
    assign icache.resptag = (in_resp & ~owner) ? bus.resptag : '0;
    assign dcache.resptag = (in_resp &  owner) ? bus.resptag : '0;

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Purpose: self-checking bench for sysbus_arbiter with grant and beat scoreboards.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: bench bus model acks requests and serves BEATS beats; client may stall respack.
module tb_sysbus_arbiter;
    localparam int TW    = 13;
    localparam int DW    = 64;
    localparam int BEATS = 8;

    logic clk = 1'b0;
    logic reset;
    logic owner;
    logic busy;

    always #5 clk = ~clk;

    sysbus_arbiter_if #(.BUS_TAG_WIDTH(TW), .BUS_DATA_WIDTH(DW)) i_if ();
    sysbus_arbiter_if #(.BUS_TAG_WIDTH(TW), .BUS_DATA_WIDTH(DW)) d_if ();
    sysbus_arbiter_if #(.BUS_TAG_WIDTH(TW), .BUS_DATA_WIDTH(DW)) bus_if ();

    sysbus_arbiter #(.BUS_TAG_WIDTH(TW), .BUS_DATA_WIDTH(DW), .BEATS(BEATS)) dut (
        .clk    (clk),
        .reset  (reset),
        .icache (i_if),
        .dcache (d_if),
        .bus    (bus_if),
        .owner  (owner),
        .busy   (busy)
    );

    typedef struct {
        bit            cli;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t grant_q[$];
    exp_t beat_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic reqcyc_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: compares every new grant and every acked beat against the scoreboards.
    always @(negedge clk) begin
        exp_t e;
        if (bus_if.reqcyc && !reqcyc_prev) begin
            if (grant_q.size() == 0) begin
                check("grant_unexpected", 1, 0);
            end else begin
                e = grant_q.pop_front();
                check("grant_owner", owner, e.cli);
                check("grant_addr", bus_if.req, e.data);
                check("grant_tag", bus_if.reqtag, e.tag);
            end
        end
        reqcyc_prev = bus_if.reqcyc;
        if (bus_if.respcyc && bus_if.respack) begin
            if (beat_q.size() == 0) begin
                check("beat_unexpected", 1, 0);
            end else begin
                e = beat_q.pop_front();
                check("beat_i_respcyc", i_if.respcyc, !e.cli);
                check("beat_d_respcyc", d_if.respcyc, e.cli);
                check("beat_data", e.cli ? d_if.resp : i_if.resp, e.data);
                check("beat_tag", e.cli ? d_if.resptag : i_if.resptag, e.tag);
                check("beat_other_resp", e.cli ? i_if.resp : d_if.resp, 0);
            end
        end
    end

    task automatic drive_req(input bit c, input bit v, input logic [DW-1:0] a, input logic [TW-1:0] t);
        if (c) begin
            d_if.reqcyc = v; d_if.req = a; d_if.reqtag = t;
        end else begin
            i_if.reqcyc = v; i_if.req = a; i_if.reqtag = t;
        end
    endtask

    task automatic push_grant(input bit c, input logic [DW-1:0] a, input logic [TW-1:0] t);
        grant_q.push_back('{c, a, t});
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // Bus model for one transaction owned by client c.
    task automatic serve(input bit c, input logic [DW-1:0] base, input logic [TW-1:0] rtag,
                         input int stall_beat, input int abort_beat,
                         input bit reissue, input logic [DW-1:0] n_addr, input logic [TW-1:0] n_tag,
                         output int gap);
        gap = 0;
        @(negedge clk);
        while (!bus_if.reqcyc && gap < 50) begin
            gap++;
            @(negedge clk);
        end
        if (!bus_if.reqcyc) begin
            check("grant_timeout", 0, 1);
            return;
        end
        @(posedge clk); #1 bus_if.reqack = 1'b1;
        @(negedge clk);
        check("reqack_owner", c ? d_if.reqack : i_if.reqack, 1);
        check("reqack_other", c ? i_if.reqack : d_if.reqack, 0);
        @(posedge clk); #1 bus_if.reqack = 1'b0;
        if (reissue) drive_req(c, 1'b1, n_addr, n_tag);
        else         drive_req(c, 1'b0, '0, '0);
        for (int k = 0; k < BEATS; k++) begin
            bus_if.respcyc = 1'b1;
            bus_if.resp    = base + DW'(k);
            bus_if.resptag = rtag;
            beat_q.push_back('{c, base + DW'(k), rtag});
            if (k == abort_beat) begin
                reset = 1'b1;
                @(negedge clk);
                @(posedge clk); #1 reset = 1'b0;
                @(negedge clk);
                check("rst_busy", busy, 0);
                check("rst_owner", owner, 1);
                check("rst_bus_reqcyc", bus_if.reqcyc, 0);
                check("rst_bus_req", bus_if.req, 0);
                check("rst_bus_reqtag", bus_if.reqtag, 0);
                check("rst_bus_respack", bus_if.respack, 0);
                check("rst_d_respcyc", d_if.respcyc, 0);
                check("rst_d_resp", d_if.resp, 0);
                check("rst_i_respcyc", i_if.respcyc, 0);
                @(posedge clk); #1 bus_if.respcyc = 1'b0;
                return;
            end
            if (k == stall_beat) begin
                if (c) d_if.respack = 1'b0; else i_if.respack = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_respack", bus_if.respack, 0);
                    check("stall_beat_cnt", dut.beat_cnt, k);
                    @(posedge clk); #1;
                end
                if (c) d_if.respack = 1'b1; else i_if.respack = 1'b1;
            end
            @(negedge clk);
            check("beat_cnt", dut.beat_cnt, k);
            @(posedge clk); #1;
        end
        bus_if.respcyc = 1'b0;
        @(negedge clk);
        check("end_idle", busy, 0);
        check("end_bus_reqcyc", bus_if.reqcyc, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int gap;
        reset = 1'b1;
        drive_req(1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, '0, '0);
        i_if.respack = 1'b1;
        d_if.respack = 1'b1;
        bus_if.reqack = 1'b0;
        bus_if.respcyc = 1'b0;
        bus_if.resp = '0;
        bus_if.resptag = '0;

        // Reset values.
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_owner", owner, 1);
        check("reset_bus_reqcyc", bus_if.reqcyc, 0);
        check("reset_bus_req", bus_if.req, 0);
        check("reset_bus_reqtag", bus_if.reqtag, 0);
        check("reset_bus_respack", bus_if.respack, 0);
        check("reset_i_reqack", i_if.reqack, 0);
        check("reset_d_respcyc", d_if.respcyc, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Single icache request.
        drive_req(1'b0, 1'b1, 64'h1000, 13'h11);
        push_grant(1'b0, 64'h1000, 13'h11);
        serve(1'b0, 64'hA0, 13'h11, -1, -1, 1'b0, '0, '0, gap);
        check("single_grant_latency", gap, 1);

        // Simultaneous requests out of reset: icache first, dcache right after turnaround.
        apply_reset();
        drive_req(1'b0, 1'b1, 64'h2000, 13'h21);
        drive_req(1'b1, 1'b1, 64'h2800, 13'h22);
        push_grant(1'b0, 64'h2000, 13'h21);
        push_grant(1'b1, 64'h2800, 13'h22);
        serve(1'b0, 64'hB0, 13'h21, -1, -1, 1'b0, '0, '0, gap);
        serve(1'b1, 64'hB8, 13'h22, -1, -1, 1'b0, '0, '0, gap);
        check("tie_second_gap", gap, 0);

        // Both clients keep requesting: grants alternate d, i, d, i.
        apply_reset();
        drive_req(1'b1, 1'b1, 64'h3000, 13'h30);
        push_grant(1'b1, 64'h3000, 13'h30);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 64'h4000, 13'h40);
        push_grant(1'b0, 64'h4000, 13'h40);
        push_grant(1'b1, 64'h3040, 13'h31);
        push_grant(1'b0, 64'h4040, 13'h41);
        serve(1'b1, 64'h300, 13'h30, -1, -1, 1'b1, 64'h3040, 13'h31, gap);
        serve(1'b0, 64'h400, 13'h40, -1, -1, 1'b1, 64'h4040, 13'h41, gap);
        check("rr_gap_i", gap, 0);
        serve(1'b1, 64'h340, 13'h31, -1, -1, 1'b0, '0, '0, gap);
        check("rr_gap_d", gap, 0);
        serve(1'b0, 64'h440, 13'h41, -1, -1, 1'b0, '0, '0, gap);
        check("rr_gap_i2", gap, 0);

        // Client stalls respack for 3 cycles on beat 4.
        drive_req(1'b0, 1'b1, 64'h5000, 13'h50);
        push_grant(1'b0, 64'h5000, 13'h50);
        serve(1'b0, 64'hC0, 13'h50, 3, -1, 1'b0, '0, '0, gap);

        // Reset during beat 5 of a dcache burst, then a fresh icache transaction.
        drive_req(1'b1, 1'b1, 64'h7000, 13'h70);
        push_grant(1'b1, 64'h7000, 13'h70);
        serve(1'b1, 64'hD0, 13'h70, -1, 4, 1'b0, '0, '0, gap);
        drive_req(1'b0, 1'b1, 64'h6000, 13'h60);
        push_grant(1'b0, 64'h6000, 13'h60);
        serve(1'b0, 64'hE0, 13'h60, -1, -1, 1'b0, '0, '0, gap);

        // Stray response pulse in IDLE.
        @(posedge clk); #1;
        bus_if.respcyc = 1'b1;
        bus_if.resp = 64'hDEAD;
        bus_if.resptag = 13'h1F;
        @(negedge clk);
        check("stray_respack", bus_if.respack, 0);
        check("stray_i_respcyc", i_if.respcyc, 0);
        check("stray_d_respcyc", d_if.respcyc, 0);
        check("stray_i_resp", i_if.resp, 0);
        @(posedge clk); #1 bus_if.respcyc = 1'b0;
        @(negedge clk);
        check("stray_busy", busy, 0);

        check("grant_q_empty", grant_q.size(), 0);
        check("beat_q_empty", beat_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
